// File: rtl/prbs_pkg.sv
// Shared constants for the PRBS-7 checker: register width, polynomial taps and state encoding.
package prbs_pkg;

    localparam int unsigned SrWidth = 7;

    // x^7 + x^6 + 1: feedback from the two most significant register bits
    localparam int unsigned TapHi = 6;
    localparam int unsigned TapLo = 5;

    localparam logic [0:0] StSeek   = 1'b0;
    localparam logic [0:0] StLocked = 1'b1;

    function automatic logic prbs7_predict(input logic [SrWidth-1:0] sr);
        return sr[TapHi] ^ sr[TapLo];
    endfunction

endpackage

// File: rtl/prbs7_lfsr.sv
// PRBS-7 shift register with next-bit prediction; load_sel picks the predicted bit (1) or din (0).
module prbs7_lfsr
    import prbs_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               shift_en,
    input  logic               load_sel,
    input  logic               din,
    output logic [SrWidth-1:0] sr,
    output logic               pred
);

    logic [SrWidth-1:0] sr_q;
    logic [SrWidth-1:0] sr_d;

    always_comb begin
        pred = prbs7_predict(sr_q);
        sr_d = sr_q;
        if (shift_en) begin
            sr_d = {sr_q[SrWidth-2:0], load_sel ? pred : din};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sr = sr_q;

endmodule

// File: rtl/prbs7_checker.sv
// PRBS-7 receive checker: seeks lock on a serial stream, then counts bit errors while locked.
// Optional build macro PRBS7_CHECKER_INJECT_EN adds an inject_err input that forces a mismatch.
module prbs7_checker
    import prbs_pkg::*;
#(
    parameter int unsigned LOCK_MATCHES = 16,
    parameter int unsigned LOSS_ERRS    = 4,
    parameter int unsigned LOSS_WINDOW  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din_valid,
    input  logic        din,
    input  logic        clr_cnt,
`ifdef PRBS7_CHECKER_INJECT_EN
    input  logic        inject_err,
`endif
    output logic        locked,
    output logic        err_trig,
    output logic [15:0] err_total
);

    localparam int unsigned MatchW = $clog2(LOCK_MATCHES + 1);
    localparam int unsigned WinW   = (LOSS_WINDOW > 1) ? $clog2(LOSS_WINDOW) : 1;
    localparam int unsigned ErrW   = $clog2(LOSS_ERRS + 1);

    logic [0:0]         state_q, state_d;
    logic [2:0]         fill_q, fill_d;
    logic [MatchW-1:0]  match_q, match_d;
    logic [WinW-1:0]    win_cnt_q, win_cnt_d;
    logic [ErrW-1:0]    win_err_q, win_err_d;
    logic               err_trig_q, err_trig_d;
    logic [15:0]        err_total_q, err_total_d;

    logic [SrWidth-1:0] sr;
    logic               pred;
    logic               mismatch;
    logic               err_now;
    logic [ErrW-1:0]    win_err_next;

    // Once locked, the register free-runs on its own prediction so a corrupted bit costs one error.
    prbs7_lfsr u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .shift_en (din_valid),
        .load_sel (state_q == StLocked),
        .din      (din),
        .sr       (sr),
        .pred     (pred)
    );

`ifdef PRBS7_CHECKER_INJECT_EN
    assign mismatch = (din != pred) || inject_err;
`else
    assign mismatch = (din != pred);
`endif

    always_comb begin
        state_d      = state_q;
        fill_d       = fill_q;
        match_d      = match_q;
        win_cnt_d    = win_cnt_q;
        win_err_d    = win_err_q;
        err_now      = 1'b0;
        win_err_next = win_err_q;

        if (din_valid) begin
            if (state_q == StSeek) begin
                win_cnt_d = '0;
                win_err_d = '0;
                if (fill_q != 3'(SrWidth)) begin
                    fill_d = fill_q + 3'd1;
                end else if (mismatch || (sr == '0)) begin
                    match_d = '0;
                end else if (match_q == MatchW'(LOCK_MATCHES - 1)) begin
                    state_d = StLocked;
                    match_d = '0;
                end else begin
                    match_d = match_q + MatchW'(1);
                end
            end else begin
                err_now      = mismatch;
                win_err_next = win_err_q + ErrW'(err_now);
                if (err_now && (win_err_next == ErrW'(LOSS_ERRS))) begin
                    state_d   = StSeek;
                    fill_d    = '0;
                    match_d   = '0;
                    win_cnt_d = '0;
                    win_err_d = '0;
                end else if (win_cnt_q == WinW'(LOSS_WINDOW - 1)) begin
                    win_cnt_d = '0;
                    win_err_d = '0;
                end else begin
                    win_cnt_d = win_cnt_q + WinW'(1);
                    win_err_d = win_err_next;
                end
            end
        end

        err_trig_d = err_now;

        err_total_d = err_total_q;
        if (clr_cnt) begin
            err_total_d = '0;
        end else if (err_now && (err_total_q != 16'hFFFF)) begin
            err_total_d = err_total_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StSeek;
            fill_q      <= '0;
            match_q     <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            err_trig_q  <= 1'b0;
            err_total_q <= '0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            err_trig_q  <= err_trig_d;
            err_total_q <= err_total_d;
        end
    end

    assign locked    = (state_q == StLocked);
    assign err_trig  = err_trig_q;
    assign err_total = err_total_q;

endmodule

// File: tb/tb_prbs7_checker.sv
// Directed bench for prbs7_checker; a second instance with a short window reaches counter saturation.
module tb_prbs7_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        din_valid;
    logic        din;
    logic        clr_cnt;
    logic        locked, err_trig;
    logic [15:0] err_total;
    logic        s_locked, s_err_trig;
    logic [15:0] s_err_total;
`ifdef PRBS7_CHECKER_INJECT_EN
    logic        inject_err = 1'b0;
`endif

    int          vectors = 0;
    int          miscompares = 0;
    logic [6:0]  gen;
    logic        exp_q[$];

    always #5 clk = ~clk;

    prbs7_checker dut (
        .clk       (clk),
        .reset     (reset),
        .din_valid (din_valid),
        .din       (din),
        .clr_cnt   (clr_cnt),
`ifdef PRBS7_CHECKER_INJECT_EN
        .inject_err(inject_err),
`endif
        .locked    (locked),
        .err_trig  (err_trig),
        .err_total (err_total)
    );

    // Window of 2 bits can never hold 3 errors, so every bit may be corrupted without losing lock.
    prbs7_checker #(.LOSS_WINDOW(2), .LOSS_ERRS(3)) sat (
        .clk       (clk),
        .reset     (reset),
        .din_valid (din_valid),
        .din       (din),
        .clr_cnt   (clr_cnt),
`ifdef PRBS7_CHECKER_INJECT_EN
        .inject_err(inject_err),
`endif
        .locked    (s_locked),
        .err_trig  (s_err_trig),
        .err_total (s_err_total)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic next_gen();
        logic b;
        b   = gen[6] ^ gen[5];
        gen = {gen[5:0], b};
        return b;
    endfunction

    task automatic cycle_check();
        logic e;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        clr_cnt   = 1'b0;
        e = exp_q.pop_front();
        check("err_trig", {31'd0, err_trig}, {31'd0, e});
    endtask

    task automatic send(input logic flip, input logic exp_trig);
        din       = next_gen() ^ flip;
        din_valid = 1'b1;
        exp_q.push_back(exp_trig);
        cycle_check();
    endtask

    task automatic send_raw(input logic b, input logic exp_trig);
        din       = b;
        din_valid = 1'b1;
        exp_q.push_back(exp_trig);
        cycle_check();
    endtask

    task automatic idle();
        din_valid = 1'b0;
        exp_q.push_back(1'b0);
        cycle_check();
    endtask

    // Drives one valid bit without scoreboarding the main instance.
    task automatic drive(input logic flip);
        din       = next_gen() ^ flip;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        clr_cnt   = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        gen   = 7'h7F;
    endtask

    task automatic lock_up(input string tag);
        for (int i = 0; i < 22; i++) send(1'b0, 1'b0);
        check({tag, "_locked_before"}, {31'd0, locked}, 32'd0);
        send(1'b0, 1'b0);
        check({tag, "_locked_after"}, {31'd0, locked}, 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        din_valid = 1'b0;
        din       = 1'b0;
        clr_cnt   = 1'b0;
        gen       = 7'h7F;
        #12;
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_err_trig", {31'd0, err_trig}, 32'd0);
        check("rst_err_total", {16'd0, err_total}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        lock_up("first");

        // Single corrupted bit at window position 5, then finish the window.
        for (int i = 0; i < 64; i++) begin
            send(i == 5, i == 5);
            if (i == 5) begin
                check("one_err_total", {16'd0, err_total}, 32'd1);
                check("one_err_locked", {31'd0, locked}, 32'd1);
            end
        end

        clr_cnt = 1'b1;
        idle();
        check("clr_total", {16'd0, err_total}, 32'd0);

        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 64; i++) begin
                send((i == 10) || (i == 20) || (i == 30), (i == 10) || (i == 20) || (i == 30));
            end
        end
        check("three_win_locked", {31'd0, locked}, 32'd1);
        check("three_win_total", {16'd0, err_total}, 32'd9);

        for (int i = 0; i < 4; i++) begin
            send(1'b1, 1'b1);
            if (i == 2) check("loss_still_locked", {31'd0, locked}, 32'd1);
        end
        check("loss_locked", {31'd0, locked}, 32'd0);
        check("loss_total", {16'd0, err_total}, 32'd13);

        lock_up("relock");

        clr_cnt = 1'b1;
        send(1'b1, 1'b1);
        check("clr_wins_total", {16'd0, err_total}, 32'd0);
        send(1'b1, 1'b1);
        check("post_clr_total", {16'd0, err_total}, 32'd1);
        check("post_clr_locked", {31'd0, locked}, 32'd1);

        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_rst_locked", {31'd0, locked}, 32'd0);
        check("async_rst_total", {16'd0, err_total}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 23; k++) begin
            send(1'b0, 1'b0);
            if (k == 21) check("gap_locked_before", {31'd0, locked}, 32'd0);
            idle();
            idle();
        end
        check("gap_locked_after", {31'd0, locked}, 32'd1);

        pulse_reset();
        for (int i = 0; i < 100; i++) send_raw(1'b0, 1'b0);
        check("zero_locked", {31'd0, locked}, 32'd0);
        check("zero_total", {16'd0, err_total}, 32'd0);

        pulse_reset();
        for (int i = 0; i < 23; i++) drive(1'b0);
        check("sat_locked", {31'd0, s_locked}, 32'd1);
        for (int i = 0; i < 65535; i++) drive(1'b1);
        check("sat_reach", {16'd0, s_err_total}, 32'h0000FFFF);
        drive(1'b1);
        check("sat_hold_trig", {31'd0, s_err_trig}, 32'd1);
        check("sat_hold_total", {16'd0, s_err_total}, 32'h0000FFFF);
        clr_cnt = 1'b1;
        drive(1'b1);
        check("sat_clr_total", {16'd0, s_err_total}, 32'd0);
        check("sat_clr_locked", {31'd0, s_locked}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prbs7_checker.md
PRBS7_CHECKER -- requirements
Module: prbs7_checker

Interface
- REQ-001 SHALL have parameter LOCK_MATCHES, default 16: consecutive matching bits required to declare lock.
- REQ-002 SHALL have parameter LOSS_ERRS, default 4: errors within one window that force loss of lock.
- REQ-003 SHALL have parameter LOSS_WINDOW, default 64: window length, counted in valid bits.
- REQ-004 SHALL have port clk, input, 1: single clock; all logic rising-edge.
- REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
- REQ-006 SHALL have port din_valid, input, 1: din is sampled this cycle.
- REQ-007 SHALL have port din, input, 1: received serial PRBS-7 bit.
- REQ-008 SHALL have port clr_cnt, input, 1: synchronous clear of err_total.
- REQ-009 SHALL have port locked, output, 1: checker in LOCKED state.
- REQ-010 SHALL have port err_trig, output, 1: one-cycle pulse per bit error; feeds the downstream saturating error counter's trig input.
- REQ-011 SHALL have port err_total, output, 16: saturating count of errors while locked.

Function
- REQ-012 SHALL implement PRBS-7 (x^7+x^6+1); predicted bit = sr[6] XOR sr[5], 7-bit shift register sr.
- REQ-013 SHALL act only on cycles with din_valid=1; din_valid=0 cycles hold all state and drive err_trig=0.
- REQ-014 SHALL use states SEEK and LOCKED.
- REQ-015 In SEEK, SHALL shift received din into sr and count consecutive matches of din against the predicted bit, after at least 7 valid bits have been loaded since entering SEEK.
- REQ-016 In SEEK, a mismatch, or sr equal to all zeros, SHALL reset the match count to 0 (no lock on all-zero data).
- REQ-017 On the valid bit that brings the match count to LOCK_MATCHES, SHALL enter LOCKED with locked=1 on the next cycle.
- REQ-018 In LOCKED, SHALL shift the predicted bit (not din) into sr, so one corrupted bit yields exactly one error.
- REQ-019 In LOCKED, SHALL register each mismatch as err_trig=1 for exactly one cycle, one clock after the sampling edge.
- REQ-020 In LOCKED, SHALL count valid bits modulo LOSS_WINDOW and errors per window; the window error count SHALL clear at window wrap.
- REQ-021 On the error that reaches LOSS_ERRS within one window, SHALL still pulse err_trig, then enter SEEK with locked=0 next cycle, clearing match, fill and window counters.
- REQ-022 SHALL increment err_total on each err_trig, saturating at 0xFFFF with no wrap.
- REQ-023 clr_cnt=1 SHALL zero err_total next cycle; clear wins over a simultaneous increment.
- REQ-024 In SEEK, mismatches SHALL NOT pulse err_trig or change err_total.

Reset
- REQ-025 reset=1 SHALL asynchronously force SEEK, sr=0, all counters=0, locked=0, err_trig=0, err_total=0.
- REQ-026 Reset asserted mid-lock SHALL discard lock; relock SHALL require the full 7-bit fill plus LOCK_MATCHES again.

Configuration
- REQ-027 With macro PRBS7_CHECKER_INJECT_EN defined, SHALL add input inject_err (1 bit); when inject_err=1 on a valid LOCKED cycle, the compare SHALL be forced to mismatch (one error).
- REQ-028 Without PRBS7_CHECKER_INJECT_EN, the port and logic SHALL be absent and behaviour per REQ-012..024.

Structure
- REQ-029 Package prbs_pkg SHALL hold the state enumeration, the PRBS-7 tap indices (6,5), and the sr width constant 7.
- REQ-030 Sub-module prbs7_lfsr SHALL contain sr plus next-bit prediction, with a load-select choosing din or the predicted bit.

Verification
- REQ-031 Reset, clean PRBS-7 from seed 7'h7F, continuous valid -> locked=1 on the cycle after valid bit 23 (7 fill + 16 matches); err_trig stays 0.
- REQ-032 Locked, one inverted bit -> exactly one err_trig pulse one clock later, err_total=1, locked stays 1.
- REQ-033 Locked, 4 inverted bits within 64 valid bits -> 4 err_trig pulses, locked=0 after the 4th; 3 errors per window repeated over 3 windows -> lock held, err_total=9.
- REQ-034 All-zero din for 100 valid bits after reset -> locked stays 0.
- REQ-035 err_total preloaded to 0xFFFF via 65535 errors -> further error holds 0xFFFF; clr_cnt coincident with an error -> err_total=0.
- REQ-036 Reset pulsed mid-lock -> locked=0 immediately; valid-gapped stream (valid every 3rd cycle) relocks after 23 valid bits.
